frac_rsh_denorm: RTL and testbench
==================================

FRAC_RSH_DENORM -- requirements
Module: frac_rsh_denorm

Interface
REQ-001 The block SHALL have parameter SIG_W, default 53, the significand width including the hidden bit.
REQ-002 The block SHALL have parameter RSH_W, default 6, the width of the right-shift amount.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port flush_i, input, 1: drops all in-flight operations.
REQ-006 Port in_valid_i, input, 1: the input operation is valid.
REQ-007 Port in_ready_o, output, 1: the block can accept an input this cycle.
REQ-008 Port sig_i, input, SIG_W: the unshifted significand, hidden bit at the MSB.
REQ-009 Port rem_nz_i, input, 1: the upstream remainder is non-zero; it is an incoming sticky bit.
REQ-010 Port rsh_i, input, RSH_W: the right-shift amount, 0..63.
REQ-011 Port out_valid_o, output, 1: the result is valid.
REQ-012 Port out_ready_i, input, 1: downstream accepts the result.
REQ-013 Port sig_o, output, SIG_W: the denormalized significand.
REQ-014 Port guard_o, output, 1: the first bit below the LSB of sig_o.
REQ-015 Port sticky_o, output, 1: OR of every bit below the guard bit, plus rem_nz_i.

Function
REQ-016 Arithmetic SHALL operate on ext = {sig_i, 1'b0}, which is SIG_W+1 bits.
- ext SHALL be shifted right logically by rsh_i.
- sig_o SHALL be ext_shifted[SIG_W:1].
- guard_o SHALL be ext_shifted[0].
- sticky_o SHALL be rem_nz_i OR the OR of all bits shifted out past bit 0.
REQ-017 When rsh_i >= SIG_W+1, sig_o and guard_o SHALL be 0, and sticky_o SHALL be (|sig_i) | rem_nz_i.
REQ-018 When rsh_i = 0, sig_o SHALL equal sig_i, guard_o SHALL be 0, and sticky_o SHALL equal rem_nz_i.
REQ-019 The block SHALL be a 2-stage pipeline.
- Stage 1 SHALL shift by 8*rsh_i[5:3], accumulate a partial sticky, and register rsh_i[2:0].
- Stage 2 SHALL shift by rsh_i[2:0], fold in its shifted-out bits, and drive the registered outputs.
REQ-020 Stage 1 SHALL keep enough low-order bits that the stage-2 guard and sticky are exact for every shift amount.
REQ-021 Latency SHALL be 2 cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o, when there is no backpressure.
REQ-022 Throughput SHALL be 1 operation per cycle while out_ready_i = 1.
REQ-023 Each stage SHALL have a valid flag. A stage SHALL advance when the stage after it is empty or is advancing.
- Stage 2 advances when out_ready_i = 1 or stage 2 is empty.
REQ-024 in_ready_o SHALL equal ~s1_valid | s1_advance. It SHALL be combinational from out_ready_i and the valid flags, and never from in_valid_i.
REQ-025 While out_valid_o = 1 and out_ready_i = 0, sig_o, guard_o and sticky_o SHALL remain stable, and no data SHALL be lost or duplicated.
REQ-026 If an input is accepted in the same cycle that stage 1 advances into stage 2, both transfers SHALL take effect.
REQ-027 When flush_i = 1, both valid flags SHALL clear on the next edge, and any input presented in that cycle SHALL be discarded.
REQ-028 When flush_i = 1, in_ready_o SHALL be 1.
REQ-029 Data registers SHALL load only when their stage accepts data; they SHALL not be reset.

Reset
REQ-030 When rst_n = 0 at a clock edge, both valid flags SHALL clear.
- out_valid_o SHALL be 0 after that edge.
- in_ready_o SHALL be 1 after that edge.
REQ-031 A reset asserted mid-operation SHALL drop all in-flight operations, with no output produced for them.
REQ-032 Reset SHALL take priority over flush_i and in_valid_i.
REQ-033 The data outputs (sig_o, guard_o, sticky_o) are don't-care while out_valid_o = 0.

Structure
REQ-034 SIG_W, RSH_W and the shifter-stage widths SHALL live in the shared package fpdivsqrt_pkg.
REQ-035 The shift-plus-sticky datapath SHALL be one combinational sub-module, frac_rsh_stage, parameterized by shift granularity and instantiated once per pipeline stage.
REQ-036 The block SHALL contain no latches and no multicycle paths.

Verification
REQ-037 sig_i=53'h10000000000000, rem_nz_i=0, rsh_i=1, out_ready_i=1 -> two cycles later sig_o=53'h08000000000000, guard_o=0, sticky_o=0.
REQ-038 sig_i=53'h1FFFFFFFFFFFFF, rsh_i=2 -> sig_o=53'h07FFFFFFFFFFFF, guard_o=1, sticky_o=1.
REQ-039 Run both of these cases:
- sig_i=53'h10000000000000, rsh_i=53 -> sig_o=0, guard_o=1, sticky_o=0.
- sig_i=53'h10000000000000, rsh_i=54 -> sig_o=0, guard_o=0, sticky_o=1.
REQ-040 Drive 6 back-to-back inputs with rsh_i=0..5 and out_ready_i=0 for cycles 3-5:
- in_ready_o SHALL drop once both stages are full;
- the outputs SHALL hold during the stall;
- all 6 results SHALL emerge in order with no loss.
REQ-041 Assert rst_n=0 (or flush_i=1) with both stages full -> out_valid_o=0 on the next cycle and in_ready_o=1. A new input then yields a correct result after 2 cycles.
REQ-042 Apply 10k random sig_i, rem_nz_i, rsh_i and random out_ready_i, and compare every result against a reference model of REQ-016 and REQ-017.

Source files
------------

// File: rtl/fpdivsqrt_pkg.sv
// Shared constants for the divide/sqrt significand path: default widths and
// the coarse/fine split used by the two-stage denormalizing shifter.
package fpdivsqrt_pkg;

    localparam int DEF_SIG_W   = 53;
    localparam int DEF_RSH_W   = 6;

    // Fine stage resolves the low FINE_W shift bits one position at a time;
    // the coarse stage moves whole groups of 2**FINE_W positions.
    localparam int FINE_W      = 3;
    localparam int FINE_GRAN   = 1;
    localparam int COARSE_GRAN = 1 << FINE_W;

    // Zero bits appended below the guard so the fine stage still sees every
    // bit that a coarse shift moved under the guard position.
    localparam int PAD_W       = (1 << FINE_W) - 1;

    function automatic int coarse_w(input int rsh_w);
        return rsh_w - FINE_W;
    endfunction

endpackage

// File: rtl/frac_rsh_stage.sv
// One combinational logical right shift by amt_i*GRAN positions; every bit
// pushed off the bottom is ORed into the outgoing sticky bit.
module frac_rsh_stage #(
    parameter int W     = 61,
    parameter int AMT_W = 3,
    parameter int GRAN  = 1
) (
    input  logic [W-1:0]     data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             sticky_i,
    output logic [W-1:0]     data_o,
    output logic             sticky_o
);

    logic [31:0] sh;
    logic [W-1:0] lost_mask;

    // A shift of W or more clears the mask shift, so all bits count as lost.
    always_comb begin
        sh        = 32'(amt_i) * 32'(GRAN);
        lost_mask = ~({W{1'b1}} << sh);
        data_o    = data_i >> sh;
        sticky_o  = sticky_i | (|(data_i & lost_mask));
    end

endmodule

// File: rtl/frac_rsh_denorm.sv
// Two-stage pipelined significand denormalizer: right shift with guard and
// sticky extraction, valid/ready flow control, flush and synchronous reset.
module frac_rsh_denorm
    import fpdivsqrt_pkg::*;
#(
    parameter int SIG_W = DEF_SIG_W,
    parameter int RSH_W = DEF_RSH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [SIG_W-1:0] sig_i,
    input  logic             rem_nz_i,
    input  logic [RSH_W-1:0] rsh_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [SIG_W-1:0] sig_o,
    output logic             guard_o,
    output logic             sticky_o
);

    localparam int CRS_W = coarse_w(RSH_W);
    localparam int S1_W  = SIG_W + 1 + PAD_W;

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never looks at the matching valid.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, s1_load;

    logic [S1_W-1:0]   ext_pad;
    logic [S1_W-1:0]   s1_data_d, s1_data_q;
    logic              s1_sticky_d, s1_sticky_q;
    logic [FINE_W-1:0] s1_fine_q;

    logic [S1_W-1:0]   fine_data;
    logic              fine_sticky;
    logic [SIG_W-1:0]  s2_sig_d, s2_sig_q;
    logic              s2_guard_d, s2_guard_q;
    logic              s2_sticky_d, s2_sticky_q;

    assign ext_pad = {sig_i, 1'b0, {PAD_W{1'b0}}};

    frac_rsh_stage #(
        .W     (S1_W),
        .AMT_W (CRS_W),
        .GRAN  (COARSE_GRAN)
    ) u_coarse (
        .data_i   (ext_pad),
        .amt_i    (rsh_i[RSH_W-1:FINE_W]),
        .sticky_i (rem_nz_i),
        .data_o   (s1_data_d),
        .sticky_o (s1_sticky_d)
    );

    frac_rsh_stage #(
        .W     (S1_W),
        .AMT_W (FINE_W),
        .GRAN  (FINE_GRAN)
    ) u_fine (
        .data_i   (s1_data_q),
        .amt_i    (s1_fine_q),
        .sticky_i (s1_sticky_q),
        .data_o   (fine_data),
        .sticky_o (fine_sticky)
    );

    // Pad bits that remain below the guard after the fine shift are sticky.
    always_comb begin
        s2_sig_d    = fine_data[S1_W-1:PAD_W+1];
        s2_guard_d  = fine_data[PAD_W];
        s2_sticky_d = fine_sticky | (|fine_data[PAD_W-1:0]);
    end

    always_comb begin
        s2_adv     = out_ready_i | ~s2_valid_q;
        s1_adv     = s1_valid_q & s2_adv;
        in_ready_o = flush_i | ~s1_valid_q | s2_adv;
        s1_load    = in_valid_i & in_ready_o & ~flush_i;
        s1_valid_d = 1'b0;
        s2_valid_d = 1'b0;
        if (!flush_i) begin
            s1_valid_d = s1_load | (s1_valid_q & ~s1_adv);
            s2_valid_d = s1_adv | (s2_valid_q & ~out_ready_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_data_q   <= s1_data_d;
            s1_sticky_q <= s1_sticky_d;
            s1_fine_q   <= rsh_i[FINE_W-1:0];
        end
        if (s1_adv) begin
            s2_sig_q    <= s2_sig_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign sig_o       = s2_sig_q;
    assign guard_o     = s2_guard_q;
    assign sticky_o    = s2_sticky_q;

endmodule

// File: tb/tb_frac_rsh_denorm.sv
// Directed and random checks of the two-stage denormalizing right shifter.
module tb_frac_rsh_denorm;

    localparam int SIG_W = 53;
    localparam int RSH_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [SIG_W-1:0] sig_i;
    logic             rem_nz_i;
    logic [RSH_W-1:0] rsh_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [SIG_W-1:0] sig_o;
    logic             guard_o;
    logic             sticky_o;

    int tests_run    = 0;
    int tests_failed = 0;

    frac_rsh_denorm #(.SIG_W(SIG_W), .RSH_W(RSH_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sig_i       (sig_i),
        .rem_nz_i    (rem_nz_i),
        .rsh_i       (rsh_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sig_o       (sig_o),
        .guard_o     (guard_o),
        .sticky_o    (sticky_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    task automatic put(input logic v, input logic [SIG_W-1:0] s, input logic r,
                       input logic [RSH_W-1:0] sh);
        in_valid_i = v;
        sig_i      = s;
        rem_nz_i   = r;
        rsh_i      = sh;
    endtask

    // Independent reference: sig_o = sig >> rsh, guard = sig[rsh-1],
    // sticky = rem | OR(sig[rsh-2:0]).
    function automatic logic [SIG_W+1:0] model(input logic [SIG_W-1:0] s, input logic r,
                                               input logic [RSH_W-1:0] sh);
        logic [63:0] s64;
        logic [63:0] so;
        logic [63:0] mask;
        logic        g;
        logic        st;
        int          n;
        n    = int'(sh);
        s64  = 64'(s);
        so   = s64 >> n;
        g    = (n == 0) ? 1'b0 : s64[n-1];
        st   = r;
        if (n >= 2) begin
            mask = (64'd1 << (n - 1)) - 64'd1;
            st   = st | (|(s64 & mask));
        end
        return {so[SIG_W-1:0], g, st};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        put(1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b exp 0", out_valid_o);
        end
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b exp 1", in_ready_o);
        end
        // Input presented while reset is held must be dropped.
        put(1'b1, 53'h10000000000000, 1'b0, 6'd1);
        @(negedge clk);
        rst_n = 1'b1;
        put(1'b0, '0, 1'b0, '0);
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (out_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_priority: out_valid got %b exp 0", out_valid_o);
            end
        end
    endtask

    task automatic test_directed();
        logic [SIG_W-1:0] v_sig [10];
        logic             v_rem [10];
        logic [RSH_W-1:0] v_rsh [10];
        logic [SIG_W+1:0] v_exp [10];
        v_sig[0] = 53'h10000000000000; v_rem[0] = 0; v_rsh[0] = 1;  v_exp[0] = {53'h08000000000000, 1'b0, 1'b0};
        v_sig[1] = 53'h1FFFFFFFFFFFFF; v_rem[1] = 0; v_rsh[1] = 2;  v_exp[1] = {53'h07FFFFFFFFFFFF, 1'b1, 1'b1};
        v_sig[2] = 53'h10000000000000; v_rem[2] = 0; v_rsh[2] = 53; v_exp[2] = {53'h0, 1'b1, 1'b0};
        v_sig[3] = 53'h10000000000000; v_rem[3] = 0; v_rsh[3] = 54; v_exp[3] = {53'h0, 1'b0, 1'b1};
        v_sig[4] = 53'h1ABCDEF0123456; v_rem[4] = 1; v_rsh[4] = 0;  v_exp[4] = {53'h1ABCDEF0123456, 1'b0, 1'b1};
        v_sig[5] = 53'h0000000000000F; v_rem[5] = 0; v_rsh[5] = 63; v_exp[5] = {53'h0, 1'b0, 1'b1};
        v_sig[6] = 53'h00000000000003; v_rem[6] = 0; v_rsh[6] = 1;  v_exp[6] = {53'h1, 1'b1, 1'b0};
        v_sig[7] = 53'h100000000000FF; v_rem[7] = 0; v_rsh[7] = 12; v_exp[7] = {53'h00010000000000, 1'b0, 1'b1};
        v_sig[8] = 53'h00000000000100; v_rem[8] = 0; v_rsh[8] = 9;  v_exp[8] = {53'h0, 1'b1, 1'b0};
        v_sig[9] = 53'h00000000000180; v_rem[9] = 0; v_rsh[9] = 8;  v_exp[9] = {53'h1, 1'b1, 1'b0};
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            put(1'b1, v_sig[i], v_rem[i], v_rsh[i]);
            @(negedge clk);
            put(1'b0, '0, 1'b0, '0);
            tests_run++;
            if (out_valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: out_valid got %b exp 0 after 1 cycle", i, out_valid_o);
            end
            @(negedge clk);
            tests_run++;
            if ({out_valid_o, sig_o, guard_o, sticky_o} !== {1'b1, v_exp[i]}) begin
                tests_failed++;
                $display("FAIL directed[%0d]: got v=%b sig=%h g=%b s=%b exp v=1 sig=%h g=%b s=%b",
                         i, out_valid_o, sig_o, guard_o, sticky_o,
                         v_exp[i][SIG_W+1:2], v_exp[i][1], v_exp[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [SIG_W+1:0] exp_tab [6];
        logic [SIG_W+1:0] held;
        logic             stalled_prev;
        logic             saw_drop;
        int               in_idx;
        int               out_idx;
        exp_tab[0] = {53'h1FFFFFFFFFFFFF, 1'b0, 1'b0};
        exp_tab[1] = {53'h0FFFFFFFFFFFFF, 1'b1, 1'b0};
        exp_tab[2] = {53'h07FFFFFFFFFFFF, 1'b1, 1'b1};
        exp_tab[3] = {53'h03FFFFFFFFFFFF, 1'b1, 1'b1};
        exp_tab[4] = {53'h01FFFFFFFFFFFF, 1'b1, 1'b1};
        exp_tab[5] = {53'h00FFFFFFFFFFFF, 1'b1, 1'b1};
        held = '0; stalled_prev = 1'b0; saw_drop = 1'b0;
        in_idx = 0; out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 6; cyc++) begin
            @(negedge clk);
            out_ready_i = !(cyc >= 3 && cyc <= 5);
            #1;
            if (stalled_prev) begin
                tests_run++;
                if ({out_valid_o, sig_o, guard_o, sticky_o} !== {1'b1, held}) begin
                    tests_failed++;
                    $display("FAIL b2b_hold cyc%0d: got v=%b sig=%h g=%b s=%b exp v=1 sig=%h g=%b s=%b",
                             cyc, out_valid_o, sig_o, guard_o, sticky_o,
                             held[SIG_W+1:2], held[1], held[0]);
                end
            end
            stalled_prev = out_valid_o & ~out_ready_i;
            if (stalled_prev) held = {sig_o, guard_o, sticky_o};
            if (out_valid_o && out_ready_i) begin
                tests_run++;
                if ({sig_o, guard_o, sticky_o} !== exp_tab[out_idx]) begin
                    tests_failed++;
                    $display("FAIL b2b_result[%0d]: got sig=%h g=%b s=%b exp sig=%h g=%b s=%b",
                             out_idx, sig_o, guard_o, sticky_o, exp_tab[out_idx][SIG_W+1:2],
                             exp_tab[out_idx][1], exp_tab[out_idx][0]);
                end
                out_idx++;
            end
            if (in_idx < 6) begin
                put(1'b1, 53'h1FFFFFFFFFFFFF, 1'b0, RSH_W'(in_idx));
                if (!in_ready_o) saw_drop = 1'b1;
                else in_idx++;
            end else begin
                put(1'b0, '0, 1'b0, '0);
            end
        end
        put(1'b0, '0, 1'b0, '0);
        out_ready_i = 1'b1;
        tests_run++;
        if (out_idx != 6) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results exp 6", out_idx);
        end
        tests_run++;
        if (saw_drop !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_drop: in_ready low seen %b exp 1", saw_drop);
        end
    endtask

    task automatic test_drop(input bit use_reset);
        @(negedge clk);
        out_ready_i = 1'b0;
        put(1'b1, 53'h1FFFFFFFFFFFFF, 1'b1, 6'd3);
        @(negedge clk);
        put(1'b1, 53'h1234567890ABC, 1'b0, 6'd4);
        @(negedge clk);
        put(1'b0, '0, 1'b0, '0);
        #1;
        tests_run++;
        if ({out_valid_o, in_ready_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL drop_full(rst=%0d): got v=%b rdy=%b exp v=1 rdy=0", use_reset, out_valid_o, in_ready_o);
        end
        put(1'b1, 53'h0F0F0F0F0F0F0F, 1'b1, 6'd5);
        if (use_reset) rst_n = 1'b0;
        else flush_i = 1'b1;
        #1;
        if (!use_reset) begin
            tests_run++;
            if (in_ready_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL flush_in_ready: got %b exp 1", in_ready_o);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; flush_i = 1'b0;
        put(1'b0, '0, 1'b0, '0);
        tests_run++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL drop_after(rst=%0d): got v=%b rdy=%b exp v=0 rdy=1", use_reset, out_valid_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_ghost(rst=%0d): out_valid got %b exp 0", use_reset, out_valid_o);
        end
        put(1'b1, 53'h10000000000000, 1'b0, 6'd1);
        @(negedge clk);
        put(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        tests_run++;
        if ({out_valid_o, sig_o, guard_o, sticky_o} !== {1'b1, 53'h08000000000000, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL drop_recover(rst=%0d): got v=%b sig=%h g=%b s=%b exp v=1 sig=08000000000000 g=0 s=0",
                     use_reset, out_valid_o, sig_o, guard_o, sticky_o);
        end
    endtask

    task automatic test_random();
        logic [SIG_W+1:0] exp_q [$];
        logic [SIG_W+1:0] exp_v;
        logic [63:0]      rnd;
        logic [RSH_W-1:0] sh;
        logic             r;
        int               accepted;
        int               errs_shown;
        accepted = 0; errs_shown = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid_o && out_ready_i) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra: unexpected result sig=%h", sig_o);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({sig_o, guard_o, sticky_o} !== exp_v) begin
                        tests_failed++;
                        if (errs_shown < 10)
                            $display("FAIL rand_result: got sig=%h g=%b s=%b exp sig=%h g=%b s=%b",
                                     sig_o, guard_o, sticky_o, exp_v[SIG_W+1:2], exp_v[1], exp_v[0]);
                        errs_shown++;
                    end
                end
            end
            rnd = {$urandom(), $urandom()};
            sh  = RSH_W'($urandom_range(0, 63));
            r   = ($urandom_range(0, 3) == 0);
            put($urandom_range(0, 3) != 0, rnd[SIG_W-1:0], r, sh);
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(model(sig_i, rem_nz_i, rsh_i));
                accepted++;
            end
            @(negedge clk);
        end
        put(1'b0, '0, 1'b0, '0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            #1;
            if (out_valid_o) begin
                tests_run++;
                exp_v = exp_q.pop_front();
                if ({sig_o, guard_o, sticky_o} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL rand_drain: got sig=%h g=%b s=%b exp sig=%h g=%b s=%b",
                             sig_o, guard_o, sticky_o, exp_v[SIG_W+1:2], exp_v[1], exp_v[0]);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (accepted != 10000 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_complete: accepted %0d exp 10000, pending %0d exp 0", accepted, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_drop(1'b0);
        test_drop(1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
